// File: rtl/fifo_pop_streamer_pkg.sv
// Shared helpers for the FIFO pop streamer.
//   wrap_inc   : advance a circular-buffer index, wrapping depth-1 -> 0
//   has_credit : true while the words held plus the word in flight still fit the buffer
package fifo_pop_streamer_pkg;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
    return (idx == depth - 1) ? 32'd0 : idx + 32'd1;
  endfunction

  function automatic logic has_credit(input int unsigned held, input int unsigned depth);
    return held < depth;
  endfunction

endpackage

// File: rtl/fifo_pop_streamer_if.sv
// Bundle of the streamer's two handshakes: the read side of async_fifo and the
// outgoing valid/ready stream.
//   fifo_empty / fifo_pop / fifo_data : FIFO read port (data registered, valid the cycle after pop)
//   valid / ready / data              : output stream
// master = the streamer, slave = the FIFO plus the stream consumer.
interface fifo_pop_streamer_if #(
  parameter int DW = 8
);
  logic          fifo_empty;
  logic          fifo_pop;
  logic [DW-1:0] fifo_data;
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    input  fifo_empty, fifo_data, ready,
    output fifo_pop, valid, data
  );

  modport slave (
    output fifo_empty, fifo_data, ready,
    input  fifo_pop, valid, data
  );
endinterface

// File: rtl/fifo_pop_streamer_buf.sv
// fifo_prefetch_buf: BUF_DEPTH x DW circular buffer with write/read indices and
// an occupancy count.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : drop all contents (indices and count to 0)
//   wr_en_i       : write wr_data_i at the write index
//   rd_en_i       : retire the head word
//   rd_data_o     : head word (storage at the read index)
//   count_o       : words held
module fifo_prefetch_buf
  import fifo_pop_streamer_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             rd_en_i,
  output logic [DW-1:0]    rd_data_o,
  output logic [CNT_W-1:0] count_o
);
  localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  logic [DW-1:0]    mem_q [BUF_DEPTH];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en_i) wr_idx_d = IDX_W'(wrap_inc(32'(wr_idx_q), 32'(BUF_DEPTH)));
      if (rd_en_i) rd_idx_d = IDX_W'(wrap_inc(32'(rd_idx_q), 32'(BUF_DEPTH)));
      // Simultaneous write and read leave the count unchanged.
      case ({wr_en_i, rd_en_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      if (wr_en_i && !clr_i) mem_q[wr_idx_q] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fifo_pop_streamer.sv
// fifo_pop_streamer: reader end of async_fifo. Pops the FIFO, absorbs its
// registered read data one cycle later into a small prefetch buffer and
// re-presents the words as a valid/ready stream at up to one word per cycle.
//   clk_i, rst_ni : FIFO read clock and its async active-low reset
//   flush_i       : discard buffered and in-flight words (FIFO itself untouched)
//   bus           : FIFO read port + output stream (master modport)
//   count_o       : words held in the buffer, excluding the one in flight
module fifo_pop_streamer
  import fifo_pop_streamer_pkg::*;
#(
  parameter int DW        = 8,
  parameter int BUF_DEPTH = 3,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  fifo_pop_streamer_if.master   bus,
  output logic [CNT_W-1:0]      count_o
);
  logic             inflight_q;
  logic             inflight_d;
  logic             pop;
  logic             valid;
  logic             fire;
  logic             capture;
  logic [DW-1:0]    head;
  logic [CNT_W-1:0] count;

  // A pop is only issued when the word it produces is guaranteed a slot, so
  // the in-flight word counts against the buffer. ready has no path here.
  // rst_ni gating keeps the pop request low while the block sits in reset.
  assign pop = rst_ni && !bus.fifo_empty && !flush_i &&
               has_credit(32'(count) + 32'(inflight_q), 32'(BUF_DEPTH));

  assign inflight_d = pop;
  assign capture    = inflight_q && !flush_i;
  assign valid      = (count != '0) && !flush_i;
  assign fire       = valid && bus.ready;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  fifo_prefetch_buf #(
    .DW        (DW),
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (flush_i),
    .wr_en_i   (capture),
    .wr_data_i (bus.fifo_data),
    .rd_en_i   (fire),
    .rd_data_o (head),
    .count_o   (count)
  );

  assign bus.fifo_pop = pop;
  assign bus.valid    = valid;
  assign bus.data     = head;
  assign count_o      = count;

endmodule

// File: tb/tb_fifo_pop_streamer.sv
module tb_fifo_pop_streamer;
  localparam int DW        = 8;
  localparam int BUF_DEPTH = 3;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] count;

  fifo_pop_streamer_if #(.DW(DW)) bus ();

  fifo_pop_streamer #(.DW(DW), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .bus     (bus),
    .count_o (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the FIFO content, the word travelling from FIFO to
  // buffer, and the words the stream still owes the consumer, in order.
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic          cap_pending = 1'b0;
  logic [DW-1:0] cap_word    = '0;
  int            pop_cnt     = 0;

  // Snapshot of DUT outputs taken mid-cycle by cycle().
  logic          s_pop, s_valid, s_fire;
  logic [DW-1:0] s_data;
  logic [CNT_W-1:0] s_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle, entered and left at a falling edge. Inputs are set by
  // the caller before the call.
  task automatic cycle();
    logic popping, flushing, exp_pop;
    bus.fifo_empty = (fifo_q.size() == 0);
    #1;
    popping  = bus.fifo_pop;
    flushing = flush;
    s_pop    = bus.fifo_pop;
    s_valid  = bus.valid;
    s_data   = bus.data;
    s_count  = count;
    s_fire   = bus.valid && bus.ready;
    exp_pop  = !bus.fifo_empty && !flushing && ((exp_q.size() + int'(cap_pending)) < BUF_DEPTH);
    check("pop_rule", popping, exp_pop);
    if (popping) pop_cnt++;
    @(posedge clk);
    #1;
    if (flushing)         exp_q.delete();
    else if (cap_pending) exp_q.push_back(cap_word);
    cap_pending = popping;
    if (popping && fifo_q.size() > 0) begin
      cap_word      = fifo_q.pop_front();
      bus.fifo_data = cap_word;
    end else begin
      bus.fifo_data = DW'($urandom);
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // Monitor: checks the stream against the expected queue every cycle and
  // retires the head word on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1) begin
        check("valid", bus.valid, (exp_q.size() != 0) && !flush);
        check("count", 32'(count), exp_q.size());
        if (bus.valid && exp_q.size() != 0) check("data", bus.data, exp_q[0]);
        if (bus.valid && bus.ready && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, last, n;
    logic got;
    logic [DW-1:0] first_word;

    rst_n = 1'b0; flush = 1'b0; bus.ready = 1'b0;
    bus.fifo_empty = 1'b1; bus.fifo_data = '0;

    // Test 1: reset values, then first-word latency.
    push_word(8'hA1);
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", bus.valid, 1'b0);
    check("rst_count", 32'(count), 0);
    check("rst_pop", bus.fifo_pop, 1'b0);
    check("rst_data", bus.data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    pop_cnt = 0;
    cycle();
    check("t1_pop_c0", s_pop, 1'b1);
    cycle();
    check("t1_valid_c1", s_valid, 1'b0);
    cycle();
    check("t1_valid_c2", s_valid, 1'b1);
    check("t1_data_c2", s_data, 8'hA1);
    check("t1_count_c2", 32'(s_count), 1);
    bus.ready = 1'b1;
    repeat (3) cycle();

    // Test 2: full-rate drain of eight preloaded words.
    for (int i = 1; i <= 8; i++) push_word(DW'(i));
    first = -1; last = -1; n = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (s_fire) begin
        n++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("t2_fires", n, 8);
    check("t2_span", last - first, 7);

    // Test 3: stalled consumer, credit stops at three pops.
    bus.ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h10 + DW'(i));
    pop_cnt = 0;
    repeat (8) cycle();
    check("t3_pops", pop_cnt, 3);
    check("t3_count", 32'(s_count), 3);
    check("t3_pop_off", s_pop, 1'b0);
    bus.ready = 1'b1;
    repeat (14) cycle();
    check("t3_drained", exp_q.size(), 0);

    // Test 4: flush with two words held and one in flight.
    bus.ready = 1'b0;
    for (int i = 0; i < 6; i++) push_word(8'h20 + DW'(i));
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    check("t4_count_pre", 32'(s_count), 2);
    flush = 1'b0;
    cycle();
    check("t4_count_post", 32'(s_count), 0);
    check("t4_valid_post", s_valid, 1'b0);
    bus.ready = 1'b1;
    got = 1'b0; first_word = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (s_fire && !got) begin
        got = 1'b1;
        first_word = s_data;
      end
    end
    check("t4_next_word", first_word, 8'h23);
    check("t4_drained", exp_q.size(), 0);

    // Test 5: random fill, random ready, occasional flush.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 40) push_word(DW'($urandom));
      bus.ready = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 99) == 0);
      cycle();
      if (s_count > CNT_W'(BUF_DEPTH)) check("t5_count_max", 32'(s_count), BUF_DEPTH);
    end
    flush = 1'b0;
    bus.ready = 1'b1;
    for (int i = 0; i < 3000 && (fifo_q.size() != 0 || exp_q.size() != 0 || cap_pending); i++) cycle();
    check("t5_fifo_empty", fifo_q.size(), 0);
    check("t5_exp_empty", exp_q.size(), 0);

    // Test 6: asynchronous reset mid-stream.
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'h60 + DW'(i));
    repeat (3) cycle();
    #2;
    check("t6_count_pre", 32'(count), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_valid", bus.valid, 1'b0);
    check("t6_count", 32'(count), 0);
    check("t6_pop", bus.fifo_pop, 1'b0);
    // The FIFO read side shares the reset, so the model restarts empty too.
    exp_q.delete();
    fifo_q.delete();
    cap_pending = 1'b0;
    bus.fifo_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    bus.ready = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'h70 + DW'(i));
    repeat (12) cycle();
    check("t6_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
